// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI master/responder pair.
// Holds the frame FSM states, word width and synchronizer depth.
package spi_pkg;

    localparam int unsigned SPI_WORD_W      = 16;
    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam int unsigned SPI_CNT_W       = $clog2(SPI_WORD_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with a trailing
// flop for edge detection. All flops reset high so reset release never fakes an edge.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned Stages = SPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // ff_q[Stages-1] is the synchronized level, ff_q[Stages] its one-clk-old copy.
    logic [Stages:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[Stages-1:0], async_i};
        end
    end

    assign sync_o = ff_q[Stages-1];
    assign rise_o = ff_q[Stages-1] & ~ff_q[Stages];
    assign fall_o = ~ff_q[Stages-1] & ff_q[Stages];

endmodule

// File: rtl/spi_resp16.sv
// SPI mode-3 style 16-bit responder: shifts tx_buf out on MISO while capturing MOSI.
// Define SPI_RESP_OVERRUN_EN to add the sticky overrun flag and its output port.
module spi_resp16
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output wire                   MISO,
    input  logic [SPI_WORD_W-1:0] tx_data,
    input  logic                  wrt,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rdy,
`ifdef SPI_RESP_OVERRUN_EN
    output logic                  overrun,
`endif
    input  logic                  clr_rdy
);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_rise;
    logic sclk_sync_unused, sclk_fall_unused, ss_sync_unused;
    logic [SPI_SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;

    spi_sync_edge u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (SS_n),
        .sync_o  (ss_sync),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (SCLK),
        .sync_o  (sclk_sync_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall_unused)
    );

    assign ss_sync_unused = ss_sync;

    // MOSI only needs a level; edges come from SCLK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q <= '1;
        end else begin
            mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_sync = mosi_q[SPI_SYNC_STAGES-1];

    state_t                state_q, state_d;
    logic [SPI_WORD_W-1:0] shft_q, shft_d, shft_nxt;
    logic [SPI_WORD_W-1:0] tx_buf_q, tx_buf_d;
    logic [SPI_WORD_W-1:0] rx_data_q, rx_data_d;
    logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;
    logic                  cmpl_q, cmpl_d;
    logic                  rdy_q, rdy_d;

    assign shft_nxt = {shft_q[SPI_WORD_W-2:0], mosi_sync};

    always_comb begin
        state_d   = state_q;
        shft_d    = shft_q;
        tx_buf_d  = tx_buf_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        cmpl_d    = 1'b0;

        // Frame start below reads tx_buf_q, so a coincident write lands in the next frame.
        if (wrt) begin
            tx_buf_d = tx_data;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    shft_d    = tx_buf_q;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise && !done_q) begin
                    shft_d    = shft_nxt;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == '1) begin
                        rx_data_d = shft_nxt;
                        done_d    = 1'b1;
                        cmpl_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdy_d = rdy_q;
        if (cmpl_q) begin
            rdy_d = 1'b1;
        end else if (clr_rdy) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shft_q    <= '0;
            tx_buf_q  <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            cmpl_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shft_q    <= shft_d;
            tx_buf_q  <= tx_buf_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            cmpl_q    <= cmpl_d;
            rdy_q     <= rdy_d;
        end
    end

`ifdef SPI_RESP_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (cmpl_d && rdy_q) begin
            overrun_d = 1'b1;
        end else if (clr_rdy) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign MISO    = (state_q == SHIFT) ? shft_q[SPI_WORD_W-1] : 1'bz;
    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule

// File: tb/tb_spi_resp16.sv
// Bench for spi_resp16: behavioural SPI master, word-level model and rdy scoreboard.
// MISO has a pull-up, so a released (high-Z) line reads as 1.
module tb_spi_resp16;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    wire         MISO;
    logic [15:0] tx_data;
    logic        wrt;
    logic [15:0] rx_data;
    logic        rdy;
    logic        clr_rdy;
    logic        stim_clr;
    logic        mon_clr;
`ifdef SPI_RESP_OVERRUN_EN
    logic        overrun;
`endif

    pullup (MISO);

    assign clr_rdy = stim_clr | mon_clr;

    spi_resp16 dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt     (wrt),
        .rx_data (rx_data),
        .rdy     (rdy),
`ifdef SPI_RESP_OVERRUN_EN
        .overrun (overrun),
`endif
        .clr_rdy (clr_rdy)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Word-level model of the responder's visible state.
    logic [15:0] m_txbuf = '0;
    logic [15:0] m_rx    = '0;
    bit          m_rdy   = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          auto_clr = 1'b0;
    logic [15:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_wrt(input logic [15:0] v);
        tx_data = v;
        wrt     = 1'b1;
        @(negedge clk);
        wrt     = 1'b0;
        m_txbuf = v;
    endtask

    task automatic stim_clear();
        stim_clr = 1'b1;
        @(negedge clk);
        stim_clr = 1'b0;
        m_rdy    = 1'b0;
        m_ovr    = 1'b0;
        @(negedge clk);
    endtask

    // Master: 32 clk per SCLK period, MOSI changes on fall, MISO sampled on rise.
    task automatic frame(input logic [15:0] cmd, input int nbits, input bit end_ss,
                         input bit co_wrt, input logic [15:0] wval, input bit co_clr);
        logic [15:0] rd;
        logic [15:0] exp_rd;
        rd     = '0;
        exp_rd = m_txbuf;
        SS_n   = 1'b0;
        if (co_wrt) begin
            // Two sync flops: wrt is high in the clk that acts on ss_fall.
            repeat (2) @(negedge clk);
            tx_data = wval;
            wrt     = 1'b1;
            @(negedge clk);
            wrt     = 1'b0;
            m_txbuf = wval;
            repeat (13) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (16) @(negedge clk);
            SCLK = 1'b1;
            rd   = {rd[14:0], MISO};
            if (i == 15) begin
                if (m_rdy) m_ovr = 1'b1;
                else sb_q.push_back(cmd);
                m_rdy = 1'b1;
                m_rx  = cmd;
            end
            if (co_clr && i == 15) begin
                repeat (2) @(negedge clk);
                stim_clr = 1'b1;
                repeat (2) @(negedge clk);
                stim_clr = 1'b0;
                chk("coincident_clr_rdy", {31'd0, rdy}, 32'd1);
                repeat (12) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        if (nbits == 16) chk("master_rd", {16'd0, rd}, {16'd0, exp_rd});
        if (end_ss) begin
            SS_n = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_rx_data"}, {16'd0, rx_data}, {16'd0, m_rx});
        chk({tag, "_rdy"}, {31'd0, rdy}, {31'd0, m_rdy});
`ifdef SPI_RESP_OVERRUN_EN
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
`endif
    endtask

    // Monitor: each rdy rise must match the oldest expected word.
    initial begin
        logic        rdy_prev;
        logic [15:0] exp;
        rdy_prev = 1'b0;
        mon_clr  = 1'b0;
        forever begin
            @(negedge clk);
            mon_clr = 1'b0;
            if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rdy", {31'd0, rdy}, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_rx_data", {16'd0, rx_data}, {16'd0, exp});
                end
                if (auto_clr) begin
                    mon_clr = 1'b1;
                    m_rdy   = 1'b0;
                end
            end
            rdy_prev = rdy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        rst      = 1'b1;
        SS_n     = 1'b1;
        SCLK     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = '0;
        wrt      = 1'b0;
        stim_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk_state("reset");
        chk("reset_miso_z", {31'd0, MISO}, 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic frame, then a second one without clearing rdy.
        do_wrt(16'hA5C3);
        frame(16'h2800, 16, 1'b1, 1'b0, 16'h0, 1'b0);
        chk_state("frame1");
        chk("idle_miso_z", {31'd0, MISO}, 32'd1);
        frame(16'h3000, 16, 1'b1, 1'b0, 16'h0, 1'b0);
        chk_state("backtoback");
        stim_clear();
        chk_state("after_clr");
        auto_clr = 1'b1;

        // Abort after 7 bits leaves rx_data/rdy untouched.
        frame(16'hBEEF, 7, 1'b1, 1'b0, 16'h0, 1'b0);
        chk_state("abort");
        frame(16'h1234, 16, 1'b1, 1'b0, 16'h0, 1'b0);
        chk_state("after_abort");

        // wrt coincident with frame start: old buffer goes out now, new one next.
        frame(16'h5555, 16, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        chk("txbuf_after_cowrt", {16'd0, m_txbuf}, 32'h0000FFFF);
        frame(16'hAAAA, 16, 1'b1, 1'b0, 16'h0, 1'b0);

        // clr_rdy in the very clk rdy rises.
        frame(16'h6789, 16, 1'b1, 1'b0, 16'h0, 1'b1);
        chk_state("after_coclr");

        // Reset at bit 9.
        frame(16'hC0DE, 9, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        m_txbuf = '0;
        m_rx    = '0;
        m_rdy   = 1'b0;
        m_ovr   = 1'b0;
        sb_q.delete();
        chk_state("midreset");
        chk("midreset_miso_z", {31'd0, MISO}, 32'd1);
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        frame(16'hC3A5, 16, 1'b1, 1'b0, 16'h0, 1'b0);
        do_wrt(16'h0F0F);
        frame(16'h5A5A, 16, 1'b1, 1'b0, 16'h0, 1'b0);
        chk_state("post_reset");

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            r = $urandom;
            if (r[31]) do_wrt(r[15:0]);
            r = $urandom;
            frame(r[15:0], 16, 1'b1, 1'b0, 16'h0, 1'b0);
            chk_state("random");
        end

        repeat (20) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
